stopwatch_counter: RTL
======================

STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchroniser flops on tick_clock (minimum 2).
REQ-002 SHALL have parameter DIGIT_WIDTH, default 4, BCD digit width.
REQ-003 SHALL have port input_clock  input  1  sole system clock; all flops on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port tick_clock  input  1  divided clock from the upstream clock_divider, treated as asynchronous level.
REQ-006 SHALL have port start_stop  input  1  single-cycle pulse, toggles run/pause.
REQ-007 SHALL have port clear  input  1  single-cycle pulse, return to 00:00 idle.
REQ-008 SHALL have ports sec_ones, sec_tens, min_ones, min_tens  output  DIGIT_WIDTH each  registered BCD time digits MM:SS.
REQ-009 SHALL have port running  output  1  high while in RUNNING.
REQ-010 SHALL have port rollover  output  1  one-cycle pulse on 59:59 -> 00:00 wrap.

Function
REQ-011 SHALL pass tick_clock through SYNC_STAGES flops, then a one-flop rising-edge detector producing internal tick, one input_clock cycle wide.
REQ-012 SHALL assert tick exactly SYNC_STAGES+1 cycles after the first input_clock edge sampling tick_clock high; one tick per tick_clock rising edge; falling edges produce nothing.
REQ-013 SHALL implement states IDLE, RUNNING, PAUSED.
REQ-014 Transitions: IDLE+start_stop -> RUNNING; RUNNING+start_stop -> PAUSED; PAUSED+start_stop -> RUNNING; any state+clear -> IDLE.
REQ-015 clear SHALL take priority over start_stop and tick in the same cycle: next cycle state IDLE, all digits 0, rollover 0.
REQ-016 Digits SHALL advance only when tick=1 and the registered state is RUNNING; tick in IDLE or PAUSED is discarded, not queued.
REQ-017 tick coincident with start_stop in RUNNING SHALL increment and enter PAUSED in the same cycle; tick coincident with start_stop in IDLE/PAUSED SHALL NOT increment.
REQ-018 Increment: sec_ones 0-9, carry to sec_tens 0-5, carry to min_ones 0-9, carry to min_tens 0-5; digits never hold values outside these ranges.
REQ-019 At 59:59 a counted tick SHALL yield 00:00, rollover=1 for exactly that next cycle, state stays RUNNING.
REQ-020 Digit, running and rollover outputs SHALL be registered; update visible one cycle after the qualifying tick/command.
REQ-021 PAUSED SHALL hold digits unchanged indefinitely.

Reset
REQ-022 reset_n low SHALL immediately force state IDLE, all digits 0, running 0, rollover 0, synchroniser and edge flops 0.
REQ-023 Reset mid-count SHALL discard the count; after release block behaves as freshly powered (IDLE, 00:00).
REQ-024 A tick_clock already high at reset release MAY produce one tick; it SHALL be ignored because state is IDLE.

Structure
REQ-025 Package stopwatch_pkg SHALL hold the state enum (IDLE, RUNNING, PAUSED), the BCD digit typedef and digit limit constants (9, 5).
REQ-026 Sub-module sync_edge_detect (parameter SYNC_STAGES; ports input_clock, reset_n, async_in, rise_pulse) SHALL implement REQ-011/012.
REQ-027 BCD increment and FSM SHALL live in stopwatch_counter; no latches, no derived clocks, tick_clock never used as a clock.

Verification
REQ-028 Reset, start_stop pulse, 3 tick_clock rising edges -> digits 00:03, running=1, each update SYNC_STAGES+2 cycles after edge.
REQ-029 Preload by ticking to 00:59, one more tick -> 01:00; ticking to 59:59, one more tick -> 00:00 with rollover high exactly one cycle, running stays 1.
REQ-030 Run to 00:05, start_stop -> PAUSED, 4 ticks -> still 00:05, running=0; start_stop, 1 tick -> 00:06.
REQ-031 clear, start_stop and tick all in the same cycle at 12:34 RUNNING -> next cycle IDLE, 00:00, rollover 0.
REQ-032 tick coincident with start_stop at 00:07 RUNNING -> 00:08 and PAUSED; reset_n pulsed low asynchronously mid-count -> outputs 0 before next clock edge.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch: FSM states,
// BCD digit type and per-digit wrap limits.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2
    } sw_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam int unsigned ONES_MAX = 9;
    localparam int unsigned TENS_MAX = 5;

endpackage

// File: rtl/sync_edge_detect.sv
// Brings an asynchronous level into the input_clock domain and emits a
// registered one-cycle pulse for every rising edge of that level.
module sync_edge_detect #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic input_clock,
    input  logic reset_n,
    input  logic async_in,
    output logic rise_pulse
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_rise;
    logic                   w_sync_out;

    assign w_sync_out = r_sync[SYNC_STAGES-1];

    always_ff @(posedge input_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
            r_prev <= w_sync_out;
            r_rise <= w_sync_out & ~r_prev;
        end
    end

    assign rise_pulse = r_rise;

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch: start/pause/clear FSM plus a BCD counter advanced by
// synchronised rising edges of tick_clock while running.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DIGIT_WIDTH = 4
) (
    input  logic                   input_clock,
    input  logic                   reset_n,
    input  logic                   tick_clock,
    input  logic                   start_stop,
    input  logic                   clear,
    output logic [DIGIT_WIDTH-1:0] sec_ones,
    output logic [DIGIT_WIDTH-1:0] sec_tens,
    output logic [DIGIT_WIDTH-1:0] min_ones,
    output logic [DIGIT_WIDTH-1:0] min_tens,
    output logic                   running,
    output logic                   rollover
);

    localparam logic [DIGIT_WIDTH-1:0] LIM_ONES = DIGIT_WIDTH'(ONES_MAX);
    localparam logic [DIGIT_WIDTH-1:0] LIM_TENS = DIGIT_WIDTH'(TENS_MAX);
    localparam logic [DIGIT_WIDTH-1:0] ONE      = DIGIT_WIDTH'(1);

    sw_state_t              r_state;
    sw_state_t              w_state_nxt;
    logic [DIGIT_WIDTH-1:0] r_sec_ones, r_sec_tens, r_min_ones, r_min_tens;
    logic [DIGIT_WIDTH-1:0] w_so_nxt, w_st_nxt, w_mo_nxt, w_mt_nxt;
    logic                   r_running;
    logic                   r_rollover;
    logic                   w_tick;
    logic                   w_count_en;
    logic                   w_wrap;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge_detect (
        .input_clock(input_clock),
        .reset_n    (reset_n),
        .async_in   (tick_clock),
        .rise_pulse (w_tick)
    );

    // Count decision uses the registered state, so a start_stop in the same
    // cycle only affects which state follows, not whether this tick counts.
    assign w_count_en = w_tick && (r_state == RUNNING);

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = IDLE;
        end else if (start_stop) begin
            case (r_state)
                IDLE:    w_state_nxt = RUNNING;
                RUNNING: w_state_nxt = PAUSED;
                PAUSED:  w_state_nxt = RUNNING;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        w_so_nxt = r_sec_ones;
        w_st_nxt = r_sec_tens;
        w_mo_nxt = r_min_ones;
        w_mt_nxt = r_min_tens;
        w_wrap   = 1'b0;
        if (w_count_en) begin
            if (r_sec_ones >= LIM_ONES) begin
                w_so_nxt = '0;
                if (r_sec_tens >= LIM_TENS) begin
                    w_st_nxt = '0;
                    if (r_min_ones >= LIM_ONES) begin
                        w_mo_nxt = '0;
                        if (r_min_tens >= LIM_TENS) begin
                            w_mt_nxt = '0;
                            w_wrap   = 1'b1;
                        end else begin
                            w_mt_nxt = r_min_tens + ONE;
                        end
                    end else begin
                        w_mo_nxt = r_min_ones + ONE;
                    end
                end else begin
                    w_st_nxt = r_sec_tens + ONE;
                end
            end else begin
                w_so_nxt = r_sec_ones + ONE;
            end
        end
    end

    always_ff @(posedge input_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_sec_ones <= '0;
            r_sec_tens <= '0;
            r_min_ones <= '0;
            r_min_tens <= '0;
            r_running  <= 1'b0;
            r_rollover <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_running <= (w_state_nxt == RUNNING);
            if (clear) begin
                r_sec_ones <= '0;
                r_sec_tens <= '0;
                r_min_ones <= '0;
                r_min_tens <= '0;
                r_rollover <= 1'b0;
            end else begin
                r_sec_ones <= w_so_nxt;
                r_sec_tens <= w_st_nxt;
                r_min_ones <= w_mo_nxt;
                r_min_tens <= w_mt_nxt;
                r_rollover <= w_wrap;
            end
        end
    end

    assign sec_ones = r_sec_ones;
    assign sec_tens = r_sec_tens;
    assign min_ones = r_min_ones;
    assign min_tens = r_min_tens;
    assign running  = r_running;
    assign rollover = r_rollover;

endmodule
